busca_instrucao: RTL and testbench

Instruction-fetch stage that feeds the field decoder. It holds the PC and issues word fetches to instruction memory over a req/ready + valid handshake, with one outstanding request. It presents the fetched 32-bit instruction and its PC through an IF/ID output register. The register supports stall, flush and branch/jump redirect.

---
 rtl/pacote_mips.sv | 20 ++
 rtl/busca_instrucao_reg_if_id.sv | 49 ++++
 rtl/busca_instrucao.sv | 116 +++++++++++
 tb/tb_busca_instrucao.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacote_mips.sv
// Shared definitions for the fetch stage: NOP word, fetch FSM states, word size.
package pacote_mips;

    localparam logic [31:0] NOP        = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } estado_t;

    // Address of the sequentially following word (32-bit wrap-around).
    function automatic logic [31:0] proximo_pc(input logic [31:0] pc);
        return pc + WORD_BYTES;
    endfunction

endpackage

// File: rtl/busca_instrucao_reg_if_id.sv
// IF/ID pipeline register: clear (flush or redirect) beats stall, stall beats load.
module reg_if_id
    import pacote_mips::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_mais4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc_mais4_q;
    logic        valid_q;

    // Clearing kills the instruction but leaves its PC fields untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP;
            pc_q       <= 32'h0;
            pc_mais4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else if (clear_i) begin
            instr_q    <= NOP;
            valid_q    <= 1'b0;
        end else if (stall_i) begin
            instr_q    <= instr_q;
            valid_q    <= valid_q;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_mais4_q <= proximo_pc(pc_i);
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_mais4_o = pc_mais4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: PC, single-outstanding fetch FSM and the IF/ID register.
module busca_instrucao
    import pacote_mips::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrucao,
    output logic [31:0] pc_out,
    output logic [31:0] pc_mais4,
    output logic        valid_out
);

    estado_t     state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        carrega;
    logic [31:0] instr_carga;
    logic [31:0] alvo;

    assign alvo = redirect_pc & ALIGN_MASK;

    // State, PC and parked response word; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ISSUE;
            pc_q    <= PC_RESET;
            pend_q  <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    // Next state and IF/ID load; a redirect always retargets the PC, whatever the state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        carrega     = 1'b0;
        instr_carga = NOP;
        if (redirect) begin
            pc_d = alvo;
        end
        case (state_q)
            ISSUE: begin
                if (imem_ready) begin
                    state_d = redirect ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (imem_valid) begin
                    if (redirect) begin
                        state_d = ISSUE;
                    end else if (stall) begin
                        pend_d  = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        carrega     = 1'b1;
                        instr_carga = imem_rdata;
                        pc_d        = proximo_pc(pc_q);
                        state_d     = ISSUE;
                    end
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pend_d  = NOP;
                    state_d = ISSUE;
                end else if (!stall) begin
                    carrega     = 1'b1;
                    instr_carga = pend_q;
                    pc_d        = proximo_pc(pc_q);
                    state_d     = ISSUE;
                end
            end
            DISCARD: begin
                if (imem_valid) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    assign imem_req  = rst_n && (state_q == ISSUE);
    assign imem_addr = pc_q;

    reg_if_id u_reg_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (flush | redirect),
        .stall_i    (stall),
        .load_i     (carrega),
        .instr_i    (instr_carga),
        .pc_i       (pc_q),
        .instr_o    (instrucao),
        .pc_o       (pc_out),
        .pc_mais4_o (pc_mais4),
        .valid_o    (valid_out)
    );

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: memory model plus a transaction-level reference of the fetch stream.
module tb_busca_instrucao;

    localparam logic [31:0] PC_INI  = 32'h0040_0000;
    localparam logic [31:0] PC_WRAP = 32'hFFFF_FFFC;
    localparam logic [31:0] MASCARA = 32'hAAAA_0000;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stall, flush, redirect, imemReady, imemValid;
    logic [31:0] redirectPc, imemRdata;
    logic        imemReq, validOut;
    logic [31:0] imemAddr, instrucao, pcOut, pcMais4;

    logic        req2, valid2, validOut2;
    logic [31:0] addr2, rdata2, instr2, pcOut2, pcMais42;

    int errors = 0;
    int checks = 0;

    // Reference model: next address to fetch, request in flight, response parked during stall.
    logic [31:0] expPc, outA, pendingA;
    bit          outstanding, outStale, pendingValid;
    logic        expValid;
    logic [31:0] expInstr, expPcOut, expPm4;

    // Memory model state.
    bit          memBusy;
    int          memCnt;
    int          memLat;
    logic [31:0] memAddr;

    busca_instrucao #(.PC_RESET(PC_INI)) dut (
        .clk(clk), .rst_n(rstN), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirectPc),
        .imem_req(imemReq), .imem_addr(imemAddr), .imem_ready(imemReady),
        .imem_valid(imemValid), .imem_rdata(imemRdata),
        .instrucao(instrucao), .pc_out(pcOut), .pc_mais4(pcMais4), .valid_out(validOut)
    );

    busca_instrucao #(.PC_RESET(PC_WRAP)) dutWrap (
        .clk(clk), .rst_n(rstN), .stall(1'b0), .flush(1'b0),
        .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(req2), .imem_addr(addr2), .imem_ready(1'b1),
        .imem_valid(valid2), .imem_rdata(rdata2),
        .instrucao(instr2), .pc_out(pcOut2), .pc_mais4(pcMais42), .valid_out(validOut2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeoutFail(input string tag);
        checks++;
        errors++;
        $error("[TB] FAIL %s: wait bound expired", tag);
    endtask

    task automatic modelReset(input logic [31:0] pcIni);
        expPc        = pcIni;
        outstanding  = 0;
        outStale     = 0;
        pendingValid = 0;
        outA         = 0;
        pendingA     = 0;
        expValid     = 0;
        expInstr     = 0;
        expPcOut     = 0;
        expPm4       = 0;
        memBusy      = 0;
        memCnt       = 0;
        memAddr      = 0;
        imemValid    = 0;
        imemRdata    = 0;
        valid2       = 0;
        rdata2       = 0;
    endtask

    task automatic checkAll();
        bit reqExp;
        reqExp = !outstanding && !pendingValid;
        checkOutput("imem_req", {31'b0, imemReq}, {31'b0, reqExp});
        if (reqExp) checkOutput("imem_addr", imemAddr, expPc);
        checkOutput("valid_out", {31'b0, validOut}, {31'b0, expValid});
        checkOutput("instrucao", instrucao, expInstr);
        checkOutput("pc_out", pcOut, expPcOut);
        checkOutput("pc_mais4", pcMais4, expPm4);
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic applyStimulus(input logic s, input logic f, input logic r,
                                 input logic [31:0] rpc, input logic rdy);
        bit          reqExp, accept, vld, deliver, acc2;
        logic [31:0] delA, capAddr, cap2;
        stall      = s;
        flush      = f;
        redirect   = r;
        redirectPc = rpc;
        imemReady  = rdy;
        #1;
        checkAll();
        reqExp  = !outstanding && !pendingValid;
        vld     = imemValid;
        accept  = imemReq && imemReady;
        capAddr = imemAddr;
        acc2    = req2;
        cap2    = addr2;
        deliver = 0;
        delA    = 0;
        if (reqExp && rdy) begin
            outstanding = 1;
            outA        = expPc;
            outStale    = r;
        end else if (outstanding && vld) begin
            outstanding = 0;
            if (!outStale && !r) begin
                if (s) begin
                    pendingValid = 1;
                    pendingA     = outA;
                end else begin
                    deliver = 1;
                    delA    = outA;
                end
            end
        end else if (outstanding && r) begin
            outStale = 1;
        end else if (pendingValid) begin
            if (r) begin
                pendingValid = 0;
            end else if (!s) begin
                deliver      = 1;
                delA         = pendingA;
                pendingValid = 0;
            end
        end
        if (r) expPc = rpc & 32'hFFFF_FFFC;
        else if (deliver) expPc = delA + 32'd4;
        if (f || r) begin
            expValid = 0;
            expInstr = 0;
        end else if (!s && deliver) begin
            expValid = 1;
            expInstr = delA ^ MASCARA;
            expPcOut = delA;
            expPm4   = delA + 32'd4;
        end
        @(posedge clk);
        #1;
        imemValid = 0;
        if (accept) begin
            memBusy = 1;
            memCnt  = memLat;
            memAddr = capAddr;
        end
        if (memBusy) begin
            memCnt--;
            if (memCnt == 0) begin
                imemValid = 1;
                imemRdata = memAddr ^ MASCARA;
                memBusy   = 0;
            end
        end
        valid2 = acc2;
        rdata2 = cap2 ^ MASCARA;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic waitIssue(input string tag);
        int n;
        n = 0;
        while ((outstanding || pendingValid) && n < 20) begin
            idle();
            n++;
        end
        if (outstanding || pendingValid) timeoutFail(tag);
    endtask

    initial begin
        rstN = 0;
        stall = 0; flush = 0; redirect = 0; redirectPc = 0; imemReady = 1;
        memLat = 1;
        modelReset(PC_INI);
        #1;
        checkOutput("reset imem_req", {31'b0, imemReq}, 32'h0);
        checkOutput("reset valid_out", {31'b0, validOut}, 32'h0);
        checkOutput("reset instrucao", instrucao, 32'h0);
        checkOutput("reset pc_out", pcOut, 32'h0);
        checkOutput("reset pc_mais4", pcMais4, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1;

        $display("[TB] streaming from PC_RESET");
        idle(); idle();
        checkOutput("first instr", instrucao, 32'hAAEA_0000);
        checkOutput("first pc_out", pcOut, 32'h0040_0000);
        checkOutput("first pc_mais4", pcMais4, 32'h0040_0004);
        checkOutput("wrap first pc_out", pcOut2, 32'hFFFF_FFFC);
        checkOutput("wrap first pc_mais4", pcMais42, 32'h0);
        checkOutput("wrap first instr", instr2, 32'h5555_FFFC);
        checkOutput("wrap first valid", {31'b0, validOut2}, 32'h1);
        checkOutput("wrap next addr", addr2, 32'h0);
        idle(); idle();
        checkOutput("second instr", instrucao, 32'hAAEA_0004);
        checkOutput("second pc_out", pcOut, 32'h0040_0004);

        $display("[TB] stall while response returns");
        idle();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        idle();
        checkOutput("after stall instr", instrucao, 32'hAAEA_0008);
        checkOutput("after stall pc_out", pcOut, 32'h0040_0008);

        $display("[TB] redirect in WAIT before data");
        memLat = 2;
        idle();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0103, 1'b1);
        idle();
        checkOutput("discard valid_out", {31'b0, validOut}, 32'h0);
        checkOutput("redirect addr", imemAddr, 32'h0040_0100);

        $display("[TB] redirect in ISSUE with ready");
        memLat = 1;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0200, 1'b1);
        idle();
        checkOutput("issue redirect addr", imemAddr, 32'h0040_0200);
        checkOutput("issue redirect valid", {31'b0, validOut}, 32'h0);
        idle(); idle();
        checkOutput("redirect instr", instrucao, 32'hAAEA_0200);
        checkOutput("redirect pc_out", pcOut, 32'h0040_0200);

        $display("[TB] flush together with stall");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("flush valid_out", {31'b0, validOut}, 32'h0);
        checkOutput("flush instr", instrucao, 32'h0);
        checkOutput("flush pc_out held", pcOut, 32'h0040_0200);

        $display("[TB] wrap-around through redirect");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 12 && !expValid; i++) idle();
        if (!expValid) timeoutFail("wrap load");
        checkOutput("wrap pc_out", pcOut, 32'hFFFF_FFFC);
        checkOutput("wrap pc_mais4", pcMais4, 32'h0);
        waitIssue("wrap issue");
        checkOutput("wrap next addr", imemAddr, 32'h0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            memLat = $urandom_range(1, 3);
            applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
                          $urandom_range(0, 99) < 6, $urandom, $urandom_range(0, 99) < 70);
        end

        $display("[TB] reset in WAIT");
        memLat = 1;
        waitIssue("pre-reset issue");
        memLat = 3;
        idle();
        rstN = 0;
        #1;
        checkOutput("midreset imem_req", {31'b0, imemReq}, 32'h0);
        checkOutput("midreset valid_out", {31'b0, validOut}, 32'h0);
        checkOutput("midreset instrucao", instrucao, 32'h0);
        checkOutput("midreset pc_out", pcOut, 32'h0);
        checkOutput("midreset pc_mais4", pcMais4, 32'h0);
        modelReset(PC_INI);
        @(negedge clk);
        rstN = 1;
        memLat = 1;
        repeat (4) idle();
        checkOutput("post reset instr", instrucao, 32'hAAEA_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
